// File: rtl/i2c_eeprom_arbiter_pkg.sv
// Shared types and default timing for the I2C EEPROM arbiter and its engine.
package i2c_eeprom_arbiter_pkg;

  // Engine command field widths
  localparam int ENG_ADDR_W = 8;
  localparam int ENG_DATA_W = 8;

  // Default timing in clk cycles at 50 MHz
  localparam int WC_CYCLES_DEF = 250000;  // 5 ms EEPROM write cycle
  localparam int TIMEOUT_DEF   = 20000;   // engine hang limit
  localparam int MAX_RETRY_DEF = 3;       // NACK retries after first attempt
  localparam int RETRY_GAP_DEF = 125;     // one 400 kHz SCL period

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_BACKOFF,
    ST_RESP
  } arb_state_e;

  // Command latched at grant and presented to the engine
  typedef struct packed {
    logic                  we;
    logic [ENG_ADDR_W-1:0] addr;
    logic [ENG_DATA_W-1:0] wdata;
  } eng_cmd_t;

endpackage

// File: rtl/i2c_eeprom_arbiter_rr_arb2.sv
// Two-way round-robin winner select; rr_ptr remembers the requester served last.
module i2c_rr_arb2
  import i2c_eeprom_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       owner,
  output logic       any,
  output logic       win
);

  logic rr_ptr_reg;

  // Winner: a lone requester wins; on contention the one not served last wins
  always_comb begin
    any = |req;
    win = (req == 2'b11) ? ~rr_ptr_reg : req[1];
  end

  // rr_ptr follows the owner of each completed command
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= 1'b0;
    end else if (upd) begin
      rr_ptr_reg <= owner;
    end
  end

endmodule

// File: rtl/i2c_eeprom_arbiter.sv
// Shares one I2C byte engine between two requesters: round-robin grant,
// NACK retry with backoff, write-cycle hold-off and hang timeout.
module i2c_eeprom_arbiter
  import i2c_eeprom_arbiter_pkg::*;
#(
  parameter int WC_CYCLES = WC_CYCLES_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF,
  parameter int RETRY_GAP = RETRY_GAP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        eng_start,
  output logic        eng_we,
  output logic [7:0]  eng_addr,
  output logic [7:0]  eng_wdata,
  output logic        eng_abort,
  input  logic        eng_done,
  input  logic        eng_nack,
  input  logic [7:0]  eng_rdata
);

  localparam int WC_W  = $clog2(WC_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam int BO_W  = $clog2(RETRY_GAP + 1);

  localparam logic [WC_W-1:0]  WC_LOAD   = WC_W'(WC_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);
  // BACKOFF plus ISSUE plus the registered eng_start put the reissue exactly
  // RETRY_GAP cycles after the NACKing eng_done.
  localparam logic [BO_W-1:0]  BO_LAST   = BO_W'(RETRY_GAP - 3);

  arb_state_e       state_reg,   state_next;
  eng_cmd_t         cmd_reg,     cmd_next;
  logic             owner_reg,   owner_next;
  logic [RTY_W-1:0] retry_reg,   retry_next;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [BO_W-1:0]  bo_cnt_reg,  bo_cnt_next;
  logic [WC_W-1:0]  wc_cnt_reg,  wc_cnt_next;
  logic             fail_reg,    fail_next;
  logic [1:0]       gnt_reg,     gnt_next;
  logic [1:0]       done_reg,    done_next;
  logic             err_reg,     err_next;
  logic [7:0]       rdata_reg,   rdata_next;
  logic             busy_reg,    busy_next;
  logic             eng_start_reg, eng_start_next;
  logic             eng_abort_reg, eng_abort_next;

  logic       arb_any, arb_win, rr_upd;
  logic [7:0] req_addr  [2];
  logic [7:0] req_wdata [2];

  // Per-requester views of the packed address/data buses
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign req_addr[gi]  = addr[gi*8 +: 8];
    assign req_wdata[gi] = wdata[gi*8 +: 8];
  end

  i2c_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .upd   (rr_upd),
    .owner (owner_reg),
    .any   (arb_any),
    .win   (arb_win)
  );

  // Next-state, counters and registered outputs
  always_comb begin
    state_next     = state_reg;
    cmd_next       = cmd_reg;
    owner_next     = owner_reg;
    retry_next     = retry_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    bo_cnt_next    = bo_cnt_reg;
    wc_cnt_next    = (wc_cnt_reg != '0) ? wc_cnt_reg - WC_W'(1) : '0;
    fail_next      = fail_reg;
    gnt_next       = 2'b00;
    done_next      = 2'b00;
    err_next       = err_reg;
    rdata_next     = rdata_reg;
    busy_next      = busy_reg;
    eng_start_next = 1'b0;
    eng_abort_next = 1'b0;
    rr_upd         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (wc_cnt_reg == '0 && arb_any) begin
          owner_next     = arb_win;
          cmd_next.we    = we[arb_win];
          cmd_next.addr  = req_addr[arb_win];
          cmd_next.wdata = req_wdata[arb_win];
          gnt_next       = arb_win ? 2'b10 : 2'b01;
          busy_next      = 1'b1;
          retry_next     = '0;
          state_next     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        eng_start_next = 1'b1;
        tmo_cnt_next   = '0;
        state_next     = ST_WAIT;
      end
      ST_WAIT: begin
        if (tmo_cnt_reg != TMO_LAST) tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        if (eng_done) begin
          if (!eng_nack) begin
            if (cmd_reg.we) wc_cnt_next = WC_LOAD;
            else            rdata_next  = eng_rdata;
            fail_next  = 1'b0;
            state_next = ST_RESP;
          end else if (retry_reg < RTY_LIMIT) begin
            retry_next  = retry_reg + RTY_W'(1);
            bo_cnt_next = '0;
            state_next  = ST_BACKOFF;
          end else begin
            fail_next  = 1'b1;
            state_next = ST_RESP;
          end
        end else if (tmo_cnt_reg == TMO_LAST) begin
          eng_abort_next = 1'b1;
          fail_next      = 1'b1;
          state_next     = ST_RESP;
        end
      end
      ST_BACKOFF: begin
        if (bo_cnt_reg == BO_LAST) state_next  = ST_ISSUE;
        else                       bo_cnt_next = bo_cnt_reg + BO_W'(1);
      end
      ST_RESP: begin
        done_next  = owner_reg ? 2'b10 : 2'b01;
        err_next   = fail_reg;
        rr_upd     = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cmd_reg       <= '0;
      owner_reg     <= 1'b0;
      retry_reg     <= '0;
      tmo_cnt_reg   <= '0;
      bo_cnt_reg    <= '0;
      wc_cnt_reg    <= '0;
      fail_reg      <= 1'b0;
      gnt_reg       <= 2'b00;
      done_reg      <= 2'b00;
      err_reg       <= 1'b0;
      rdata_reg     <= '0;
      busy_reg      <= 1'b0;
      eng_start_reg <= 1'b0;
      eng_abort_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_reg       <= cmd_next;
      owner_reg     <= owner_next;
      retry_reg     <= retry_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      bo_cnt_reg    <= bo_cnt_next;
      wc_cnt_reg    <= wc_cnt_next;
      fail_reg      <= fail_next;
      gnt_reg       <= gnt_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      rdata_reg     <= rdata_next;
      busy_reg      <= busy_next;
      eng_start_reg <= eng_start_next;
      eng_abort_reg <= eng_abort_next;
    end
  end

  assign gnt       = gnt_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign rdata     = rdata_reg;
  assign busy      = busy_reg;
  assign eng_start = eng_start_reg;
  assign eng_abort = eng_abort_reg;
  assign eng_we    = cmd_reg.we;
  assign eng_addr  = cmd_reg.addr;
  assign eng_wdata = cmd_reg.wdata;

endmodule

// File: tb/tb_i2c_eeprom_arbiter.sv
// Directed bench for i2c_eeprom_arbiter with a behavioural I2C engine model.
module tb_i2c_eeprom_arbiter;

  localparam int WC  = 40;
  localparam int TO  = 60;
  localparam int MR  = 3;
  localparam int RG  = 125;
  localparam int LIM = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  gnt, done;
  logic        err, busy, eng_start, eng_we, eng_abort;
  logic [7:0]  rdata, eng_addr, eng_wdata;
  logic        eng_done = 1'b0;
  logic        eng_nack = 1'b0;
  logic [7:0]  eng_rdata = '0;

  i2c_eeprom_arbiter #(
    .WC_CYCLES (WC),
    .TIMEOUT   (TO),
    .MAX_RETRY (MR),
    .RETRY_GAP (RG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_we    (eng_we),
    .eng_addr  (eng_addr),
    .eng_wdata (eng_wdata),
    .eng_abort (eng_abort),
    .eng_done  (eng_done),
    .eng_nack  (eng_nack),
    .eng_rdata (eng_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  // Engine model plan, written only by the main sequence
  int         nack_cfg   = 0;      // -1: always NACK, else NACK the first N attempts
  bit         hang       = 1'b0;   // never answer
  logic [7:0] rd_plan    = '0;
  int         inject_req = 0;      // bump to force one stray eng_done

  // Engine model observations, written only by the engine process
  int         start_cnt = 0, start_cyc = 0, done_cyc = 0;
  int         abort_cnt = 0, abort_cyc = 0;
  int         gap_seen = 0, gap_bad = 0;
  logic       seen_we = 1'b0;
  logic [7:0] seen_addr = '0, seen_wdata = '0;

  // Behavioural engine: answers 5 cycles after eng_start, NACKs per plan
  initial begin
    bit pend;
    int pend_cnt, attempt, inject_ack;
    bit last_nack;
    pend = 0; pend_cnt = 0; attempt = 0; inject_ack = 0; last_nack = 0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      eng_nack = 1'b0;
      if (rst) begin pend = 0; last_nack = 0; end
      if (eng_abort) begin pend = 0; last_nack = 0; abort_cnt++; abort_cyc = cyc; end
      if (gnt != 2'b00) begin attempt = 0; last_nack = 0; end
      if (inject_ack != inject_req) begin
        inject_ack = inject_req;
        eng_done   = 1'b1;
        eng_rdata  = 8'hEE;
      end else if (pend) begin
        if (pend_cnt == 0) begin
          pend      = 0;
          eng_done  = 1'b1;
          done_cyc  = cyc;
          eng_rdata = rd_plan;
          eng_nack  = (nack_cfg < 0) || (attempt < nack_cfg);
          last_nack = eng_nack;
          attempt++;
        end else begin
          pend_cnt--;
        end
      end
      if (eng_start) begin
        if (last_nack) begin
          gap_seen++;
          if (cyc - done_cyc != RG) gap_bad++;
        end
        last_nack  = 0;
        start_cnt++;
        start_cyc  = cyc;
        seen_we    = eng_we;
        seen_addr  = eng_addr;
        seen_wdata = eng_wdata;
        if (!hang) begin pend = 1; pend_cnt = 4; end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h required=%0h", name, got, exp);
  endtask

  // One command from requester r; returns request, grant and done cycles
  task automatic do_cmd(input int r, input bit w, input logic [7:0] a, input logic [7:0] d,
                        output int t0, output int tg, output int td,
                        output bit e, output logic [7:0] rd);
    bit ok;
    int s0;
    @(negedge clk);
    req[r] = 1'b1;
    we[r]  = w;
    addr[r*8 +: 8]  = a;
    wdata[r*8 +: 8] = d;
    t0 = cyc; tg = -1; td = -1; e = 1'b0; rd = '0; ok = 1'b0;
    s0 = start_cnt;
    for (int i = 0; i < LIM; i++) begin
      @(negedge clk);
      if (gnt[r]) begin tg = cyc; req[r] = 1'b0; end
      if (done[r]) begin td = cyc; e = err; rd = rdata; ok = 1'b1; break; end
    end
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL cmd_done r=%0d got no done in %0d cycles, required a done pulse", r, LIM);
    $display("txn r=%0d we=%0d addr=%02h wdata=%02h gnt@%0d done@%0d err=%0d rdata=%02h starts=%0d",
             r, w, a, d, tg, td, e, rd, start_cnt - s0);
  endtask

  typedef struct {
    int         r;
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] erd;
    int         nacks;
    bit         exp_err;
    logic [7:0] exp_rd;
    int         exp_starts;
  } vec_t;

  vec_t vt [6];

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required $finish");
    $fatal(1);
  end

  initial begin
    int t0, tg, td, td_prev, got, dn, s0, g0, b0, a0, cnt;
    bit e;
    logic [7:0] rd;
    int served [2];

    vt[0] = '{1, 1'b0, 8'h1E, 8'h00, 8'h05,  2, 1'b0, 8'h05, 3};
    vt[1] = '{0, 1'b0, 8'h33, 8'h00, 8'hA7, -1, 1'b1, 8'h05, 4};
    vt[2] = '{0, 1'b1, 8'h40, 8'hC3, 8'h99,  1, 1'b0, 8'h05, 2};
    vt[3] = '{1, 1'b0, 8'h40, 8'h00, 8'hC3,  0, 1'b0, 8'hC3, 1};
    vt[4] = '{1, 1'b1, 8'h7F, 8'hFF, 8'h12,  3, 1'b0, 8'hC3, 4};
    vt[5] = '{0, 1'b0, 8'h01, 8'h00, 8'h5A,  4, 1'b1, 8'hC3, 4};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {gnt, done, err, rdata, busy, eng_start, eng_we,
                          eng_addr, eng_wdata, eng_abort}, '0);
    rst = 1'b0;

    // Write, then a read that must wait out the write cycle
    do_cmd(0, 1'b1, 8'h1E, 8'h05, t0, tg, td, e, rd);
    chk("t1_gnt_latency", tg - t0, 1);
    chk("t1_start_latency", start_cyc - t0, 2);
    chk("t1_err", e, 0);
    chk("t1_eng_fields", {seen_we, seen_addr, seen_wdata}, {1'b1, 8'h1E, 8'h05});
    td_prev = td;
    rd_plan = 8'h11;
    do_cmd(1, 1'b0, 8'h2A, 8'h00, t0, tg, td, e, rd);
    chk("t1_wc_holdoff", (tg - td_prev >= WC) && (tg - td_prev <= WC + 2), 1);
    chk("t1_read_rdata", rd, 8'h11);

    // Both requesting continuously: strict alternation starting with 0
    rd_plan = 8'h22;
    served[0] = 0; served[1] = 0;
    @(negedge clk);
    we = 2'b00; addr = 16'h0201; req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      got = -1; dn = 0;
      for (int i = 0; i < LIM && dn == 0; i++) begin
        @(negedge clk);
        if (got < 0) begin
          if (gnt[0]) got = 0;
          else if (gnt[1]) got = 1;
          if (got >= 0) req[got] = 1'b0;
        end
        if (got >= 0 && done[got]) begin
          dn = 1;
          served[got]++;
          if (served[got] < 3) req[got] = 1'b1;
        end
      end
      $display("txn rr k=%0d winner=%0d", k, got);
      chk($sformatf("rr_order_%0d", k), got, k % 2);
    end
    req = 2'b00;

    // Table: NACK retry, exhaustion, writes and reads
    for (int i = 0; i < 6; i++) begin
      nack_cfg = vt[i].nacks;
      rd_plan  = vt[i].erd;
      s0 = start_cnt; g0 = gap_seen; b0 = gap_bad;
      do_cmd(vt[i].r, vt[i].w, vt[i].a, vt[i].d, t0, tg, td, e, rd);
      chk($sformatf("v%0d_err", i), e, vt[i].exp_err);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d_starts", i), start_cnt - s0, vt[i].exp_starts);
      chk($sformatf("v%0d_gaps_seen", i), gap_seen - g0, vt[i].exp_starts - 1);
      chk($sformatf("v%0d_gaps_bad", i), gap_bad - b0, 0);
      chk($sformatf("v%0d_eng_addr", i), seen_addr, vt[i].a);
    end
    nack_cfg = 0;

    // Engine hang: abort after TIMEOUT, done the cycle after
    hang = 1'b1;
    a0 = abort_cnt;
    do_cmd(0, 1'b0, 8'h10, 8'h00, t0, tg, td, e, rd);
    chk("to_abort_latency", abort_cyc - start_cyc, TO);
    chk("to_done_after_abort", td - abort_cyc, 1);
    chk("to_err", e, 1);
    chk("to_abort_count", abort_cnt - a0, 1);
    chk("to_rdata_hold", rd, 8'hC3);
    @(negedge clk);
    chk("to_idle_busy", busy, 0);

    // Reset while waiting on a hung engine
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[7:0] = 8'h44;
    s0 = start_cnt;
    for (int i = 0; i < 20 && start_cnt == s0; i++) begin
      @(negedge clk);
      if (gnt[0]) req[0] = 1'b0;
    end
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_outputs", {gnt, done, err, rdata, busy, eng_start, eng_we,
                             eng_addr, eng_wdata, eng_abort}, '0);
    rst  = 1'b0;
    hang = 1'b0;
    inject_req++;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done != 2'b00 || eng_start || busy) cnt++;
    end
    $display("txn late_eng_done activity=%0d", cnt);
    chk("late_done_ignored", cnt, 0);
    chk("late_rdata", rdata, 8'h00);

    // Reset while the write-cycle counter is running
    do_cmd(0, 1'b1, 8'h50, 8'hAB, t0, tg, td, e, rd);
    chk("rst_wc_write_err", e, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_plan = 8'h3C;
    do_cmd(1, 1'b0, 8'h50, 8'h00, t0, tg, td, e, rd);
    chk("rst_wc_gnt_latency", tg - t0, 1);
    chk("rst_wc_read_rdata", rd, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
